// File: rtl/cmp_seq_ctrl.sv
// Byte-serial word comparator sequencer: walks a shared 8-bit magnitude comparator
// over NBYTES-wide operands, MSB byte first, and reports word-level EQ/LT/GT.
module cmp_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  SIGNED,
    output logic [7:0]            CMP_A,
    output logic [7:0]            CMP_B,
    input  logic                  CMP_EQ,
    input  logic                  CMP_LT,
    input  logic                  CMP_GT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  EQ,
    output logic                  LT,
    output logic                  GT
);

    // state | meaning
    // IDLE  | waiting for START; comparator inputs parked at zero
    // CMP   | presenting byte[r_idx] to the comparator, one byte per cycle
    // FIN   | result flags valid, DONE high for this single cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(NBYTES - 1);

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [8*NBYTES-1:0]   r_a;
    logic [8*NBYTES-1:0]   r_b;
    logic                  r_signed;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_eq;
    logic                  r_lt;
    logic                  r_gt;

    logic [7:0]            w_sel_a;
    logic [7:0]            w_sel_b;
    logic [7:0]            w_cmp_a;
    logic [7:0]            w_cmp_b;
    logic                  w_unused;

    // GT from the comparator is redundant once EQ=0: GT is simply ~LT.
    assign w_unused = CMP_GT;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_a = r_a[i*8 +: 8];
                w_sel_b = r_b[i*8 +: 8];
            end
        end
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        w_cmp_a = '0;
        w_cmp_b = '0;
        if (r_state == S_CMP) begin
            w_cmp_a = w_sel_a;
            w_cmp_b = w_sel_b;
            if (r_signed && (r_idx == IDX_MSB)) begin
                w_cmp_a[7] = ~w_sel_a[7];
                w_cmp_b[7] = ~w_sel_b[7];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= SIGNED;
                        r_idx    <= IDX_MSB;
                        r_busy   <= 1'b1;
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (!CMP_EQ) begin
                        r_eq    <= 1'b0;
                        r_lt    <= CMP_LT;
                        r_gt    <= ~CMP_LT;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (r_idx == '0) begin
                        r_eq    <= 1'b1;
                        r_lt    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CMP_A = w_cmp_a;
    assign CMP_B = w_cmp_b;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign EQ    = r_eq;
    assign LT    = r_lt;
    assign GT    = r_gt;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl with a behavioural 8-bit comparator attached.
module tb_cmp_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          SIGNED;
    logic [7:0]    CMP_A;
    logic [7:0]    CMP_B;
    logic          CMP_EQ;
    logic          CMP_LT;
    logic          CMP_GT;
    logic          BUSY;
    logic          DONE;
    logic          EQ;
    logic          LT;
    logic          GT;

    int n_vec;
    int n_err;

    cmp_seq_ctrl #(.NBYTES(NB)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .SIGNED(SIGNED),
        .CMP_A(CMP_A), .CMP_B(CMP_B), .CMP_EQ(CMP_EQ), .CMP_LT(CMP_LT), .CMP_GT(CMP_GT),
        .BUSY(BUSY), .DONE(DONE), .EQ(EQ), .LT(LT), .GT(GT)
    );

    assign CMP_EQ = (CMP_A == CMP_B);
    assign CMP_LT = (CMP_A <  CMP_B);
    assign CMP_GT = (CMP_A >  CMP_B);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [2:0]   flags;   // {EQ, LT, GT}
        int           k;
        logic [7:0]   ca;
        logic [7:0]   cb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: word order from plain arithmetic, bytes examined = leading equal bytes + 1.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic lt;
        if (a == b) return 3'b100;
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        return lt ? 3'b010 : 3'b001;
    endfunction

    function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = NB - 1; i >= 0; i--)
            if (a[i*8 +: 8] != b[i*8 +: 8]) return NB - i;
        return NB;
    endfunction

    task automatic run_cmp(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [2:0] eflags, input int ek,
                           input logic [7:0] eca, input logic [7:0] ecb);
        int n;
        @(negedge CLK);
        START = 1'b1; A = a; B = b; SIGNED = s;
        @(posedge CLK); #1;
        START = 1'b0;
        A = ~a; B = ~b; SIGNED = ~s;   // changes while busy must not matter
        chk({nm, ".busy"}, W'(BUSY), W'(1));
        chk({nm, ".cmp_a0"}, W'(CMP_A), W'(eca));
        chk({nm, ".cmp_b0"}, W'(CMP_B), W'(ecb));
        n = 1;
        while (!DONE && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({nm, ".latency"}, W'(n), W'(ek + 1));
        chk({nm, ".flags"}, W'({EQ, LT, GT}), W'(eflags));
        @(posedge CLK); #1;
        chk({nm, ".done_pulse"}, W'({BUSY, DONE}), W'(0));
        chk({nm, ".flags_hold"}, W'({EQ, LT, GT}), W'(eflags));
    endtask

    initial begin
        int dones;
        logic [W-1:0] ra, rb;
        logic         rs;
        int           sel;
        logic [7:0]   msk;

        n_vec = 0; n_err = 0;
        RST_N = 1'b0; START = 1'b1; A = 32'hFFFF_FFFF; B = '0; SIGNED = 1'b0;

        vecs[0] = '{32'h1234_5678, 32'h11FF_FFFF, 1'b0, 3'b001, 1, 8'h12, 8'h11};
        vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b100, 4, 8'hDE, 8'hDE};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b010, 1, 8'h7F, 8'h80};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 1, 8'hFF, 8'h00};
        vecs[4] = '{32'h0000_00FE, 32'h0000_00FF, 1'b0, 3'b010, 4, 8'h00, 8'h00};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010, 1, 8'h00, 8'hFF};
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, 1, 8'h80, 8'h7F};
        vecs[7] = '{32'h1234_5600, 32'h1234_5601, 1'b1, 3'b010, 4, 8'h92, 8'h92};

        // Reset with START held high
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst.busy_done", W'({BUSY, DONE}), W'(0));
        chk("rst.flags", W'({EQ, LT, GT}), W'(0));
        chk("rst.cmp", W'({CMP_A, CMP_B}), W'(0));
        @(negedge CLK);
        START = 1'b0; RST_N = 1'b1;

        foreach (vecs[i])
            run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                    vecs[i].flags, vecs[i].k, vecs[i].ca, vecs[i].cb);

        // Full-length equal: byte walk DE, AD, BE, EF and 5 busy cycles
        @(negedge CLK);
        START = 1'b1; A = 32'hDEAD_BEEF; B = 32'hDEAD_BEEF; SIGNED = 1'b0;
        @(negedge CLK); START = 1'b0;
        chk("walk.b3", W'(CMP_A), W'(8'hDE));
        @(negedge CLK); chk("walk.b2", W'(CMP_A), W'(8'hAD));
        @(negedge CLK); chk("walk.b1", W'(CMP_A), W'(8'hBE));
        @(negedge CLK); chk("walk.b0", W'({CMP_A, CMP_B}), W'(16'hEFEF));
        @(negedge CLK); chk("walk.fin", W'({BUSY, DONE, EQ}), W'(3'b111));
        @(negedge CLK); chk("walk.idle", W'({BUSY, DONE}), W'(0));

        // START during CMP is ignored
        @(negedge CLK);
        START = 1'b1; A = 32'h0000_00FE; B = 32'h0000_00FF; SIGNED = 1'b0;
        @(negedge CLK); START = 1'b0;
        @(negedge CLK);
        START = 1'b1; A = 32'hFFFF_FFFF; B = 32'h0; SIGNED = 1'b0;
        @(negedge CLK); START = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        chk("ignore.dones", W'(dones), W'(1));
        chk("ignore.flags", W'({EQ, LT, GT}), W'(3'b010));

        // Reset during the second CMP cycle
        START = 1'b1; A = 32'h1234_5600; B = 32'h1234_5601; SIGNED = 1'b0;
        @(negedge CLK); START = 1'b0;
        chk("midrst.c1", W'({BUSY, DONE}), W'(2'b10));
        @(negedge CLK);
        chk("midrst.c2", W'({BUSY, DONE}), W'(2'b10));
        RST_N = 1'b0;
        @(negedge CLK);
        chk("midrst.state", W'({BUSY, DONE}), W'(0));
        chk("midrst.flags", W'({EQ, LT, GT}), W'(0));
        RST_N = 1'b1;
        @(negedge CLK);
        chk("midrst.nodone", W'(DONE), W'(0));
        run_cmp("midrst.rerun", 32'h1234_5600, 32'h1234_5601, 1'b0, 3'b010, 4, 8'h12, 8'h12);

        // Randomized against the reference model
        for (int t = 0; t < 150; t++) begin
            ra  = W'($urandom);
            rs  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            case (sel)
                0: rb = W'($urandom);
                1: rb = ra;
                2: begin
                    rb = ra;
                    msk = 8'($urandom);
                    rb[$urandom_range(0, NB - 1) * 8 +: 8] = msk;
                end
                default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            run_cmp($sformatf("rnd%0d", t), ra, rb, rs, ref_flags(ra, rb, rs), ref_k(ra, rb),
                    ra[W-1 -: 8] ^ {rs, 7'b0}, rb[W-1 -: 8] ^ {rs, 7'b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
